vga_line_fetch: RTL

- Pixel-source stage directly upstream of the VGA timing/output block.
- Fetches one visible line of RGB332 pixels from the framebuffer RAM into a double-buffered line buffer during the previous line.
- Streams expanded 24-bit RGB in step with the timing block's display-active signal and pixel strobe.
- Hides RAM read latency from the timing block and flags line underruns.

---
 rtl/vga_line_fetch.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/vga_line_fetch.sv
// vga_line_fetch: fills one RGB332 line from framebuffer RAM into a
// double-buffered line buffer and streams expanded 24-bit RGB to the VGA
// timing/output stage with a fixed one-pixel latency.
module vga_line_fetch #(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter int          ADDR_W   = 19,
  parameter int unsigned FB_BASE  = 0
) (
  input  logic                        CLOCK_50,
  input  logic                        RESET,
  input  logic                        pix_en,
  input  logic                        disp_active,
  input  logic                        swap,
  input  logic                        fetch_go,
  input  logic [$clog2(V_ACTIVE)-1:0] fetch_line,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_rd,
  input  logic [7:0]                  mem_rdata,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        fetch_busy,
  output logic                        underrun
);

  localparam int LINE_W = $clog2(V_ACTIVE);
  localparam int PW     = $clog2(H_ACTIVE);
  localparam logic [PW-1:0] LAST = PW'(H_ACTIVE - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ISSUE, S_DRAIN} state_t;

  state_t              state_q;
  logic [LINE_W-1:0]   line_q;
  logic [ADDR_W-1:0]   line_base_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_rd_q;
  logic [PW-1:0]       wr_ptr_q;
  logic                rd_valid_q;
  logic [PW-1:0]       rd_idx_q;
  logic                underrun_q;
  logic                fill_bank_q;
  logic [PW-1:0]       rd_ptr_q;
  logic [23:0]         rgb_q;
  logic [7:0]          lb_q [2][H_ACTIVE];

  logic [ADDR_W-1:0]   line_ext;
  logic [ADDR_W-1:0]   base_calc;
  logic [7:0]          disp_pix;

  assign line_ext = ADDR_W'(line_q);

  // Line base address; the 640 case is built from two shifts and an add.
  always_comb begin
    base_calc = '0;
    if (H_ACTIVE == 640)
      base_calc = ADDR_W'(FB_BASE) + (line_ext << 9) + (line_ext << 7);
    else
      base_calc = ADDR_W'(FB_BASE) + line_ext * ADDR_W'(H_ACTIVE);
  end

  function automatic logic [23:0] expand(input logic [7:0] p);
    return {p[7:5], p[7:5], p[7:6], p[4:2], p[4:2], p[4:3], {4{p[1:0]}}};
  endfunction

  // Fetch FSM, bank select and underrun flag. A swap while busy aborts the
  // fill and also cancels the read already in flight.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      line_q      <= '0;
      line_base_q <= '0;
      mem_addr_q  <= '0;
      mem_rd_q    <= 1'b0;
      wr_ptr_q    <= '0;
      rd_valid_q  <= 1'b0;
      rd_idx_q    <= '0;
      underrun_q  <= 1'b0;
      fill_bank_q <= 1'b1;
    end else begin
      rd_valid_q <= mem_rd_q;
      rd_idx_q   <= wr_ptr_q;
      if (swap) fill_bank_q <= ~fill_bank_q;
      if (swap && state_q != S_IDLE) begin
        underrun_q <= 1'b1;
        state_q    <= S_IDLE;
        mem_rd_q   <= 1'b0;
        rd_valid_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (fetch_go) begin
              line_q  <= fetch_line;
              state_q <= S_SETUP;
            end
          end
          S_SETUP: begin
            line_base_q <= base_calc;
            mem_addr_q  <= base_calc;
            mem_rd_q    <= 1'b1;
            wr_ptr_q    <= '0;
            state_q     <= S_ISSUE;
          end
          S_ISSUE: begin
            if (wr_ptr_q == LAST) begin
              mem_rd_q <= 1'b0;
              state_q  <= S_DRAIN;
            end else begin
              wr_ptr_q   <= wr_ptr_q + 1'b1;
              mem_addr_q <= line_base_q + ADDR_W'(wr_ptr_q) + ADDR_W'(1);
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // Line buffer write: returned word lands at the index of the read that
  // produced it; suppressed on reset and on the swap that aborts a fill.
  always_ff @(posedge CLOCK_50) begin
    if (rd_valid_q && !swap && !RESET)
      lb_q[fill_bank_q][rd_idx_q] <= mem_rdata;
  end

  assign disp_pix = lb_q[~fill_bank_q][rd_ptr_q];

  // Display path: advances only on pix_en; swap restarts the line.
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      rd_ptr_q <= '0;
      rgb_q    <= '0;
    end else begin
      if (pix_en) begin
        if (disp_active) begin
          rgb_q <= expand(disp_pix);
          if (rd_ptr_q != LAST) rd_ptr_q <= rd_ptr_q + 1'b1;
        end else begin
          rgb_q <= '0;
        end
      end
      if (swap) rd_ptr_q <= '0;
    end
  end

  assign mem_addr   = mem_addr_q;
  assign mem_rd     = mem_rd_q;
  assign fetch_busy = (state_q != S_IDLE);
  assign underrun   = underrun_q;
  assign VGA_R      = rgb_q[23:16];
  assign VGA_G      = rgb_q[15:8];
  assign VGA_B      = rgb_q[7:0];

endmodule
